// File: rtl/rv32_wb_scoreboard.sv
// Writeback/hazard stage for the RV32E register file: ALU/load write-port merge,
// a 1-entry load skid buffer, and a per-register busy mask with an outstanding-load limit.
module rv32_wb_scoreboard #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [3:0]      iss_rs1,
  input  logic [3:0]      iss_rs2,
  input  logic            iss_use_rs1,
  input  logic            iss_use_rs2,
  input  logic [3:0]      iss_rd,
  input  logic            iss_is_load,
  input  logic            alu_wb_valid,
  input  logic [3:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  input  logic            ld_rsp_valid,
  output logic            ld_rsp_ready,
  input  logic [3:0]      ld_rsp_rd,
  input  logic [XLEN-1:0] ld_rsp_data,
  output logic [3:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data,
  output logic            rf_rd_we,
  output logic [15:0]     busy_mask
);

  localparam int CW = 3;

  logic            skid_valid;
  logic [3:0]      skid_rd;
  logic [XLEN-1:0] skid_data;
  logic [CW-1:0]   count;
  logic [15:0]     busy;

  logic            ld_fire;
  logic            cap_skid;
  logic            drain_skid;
  logic            commit;
  logic            issue_load;
  logic            dec;
  logic [3:0]      commit_rd;
  logic [15:0]     set_mask;
  logic [15:0]     clr_mask;

  assign ld_rsp_ready = !skid_valid;
  assign ld_fire      = ld_rsp_valid && !skid_valid;
  assign cap_skid     = ld_fire && alu_wb_valid;
  assign drain_skid   = skid_valid && !alu_wb_valid;
  assign commit       = drain_skid || (ld_fire && !alu_wb_valid);
  assign commit_rd    = skid_valid ? skid_rd : ld_rsp_rd;

  always_comb begin
    rf_rd_addr = '0;
    rf_rd_data = '0;
    rf_rd_we   = 1'b0;
    if (alu_wb_valid) begin
      rf_rd_addr = alu_wb_rd;
      rf_rd_data = alu_wb_data;
      rf_rd_we   = (alu_wb_rd != 4'd0);
    end else if (skid_valid) begin
      rf_rd_addr = skid_rd;
      rf_rd_data = skid_data;
      rf_rd_we   = (skid_rd != 4'd0);
    end else if (ld_fire) begin
      rf_rd_addr = ld_rsp_rd;
      rf_rd_data = ld_rsp_data;
      rf_rd_we   = (ld_rsp_rd != 4'd0);
    end
    // An ALU result presented during reset must not reach the file.
    if (!rst_n) rf_rd_we = 1'b0;
  end

  assign iss_ready = !(iss_use_rs1 && busy[iss_rs1]) &&
                     !(iss_use_rs2 && busy[iss_rs2]) &&
                     !((iss_rd != 4'd0) && busy[iss_rd]) &&
                     !(iss_is_load && (count == CW'(MAX_OUTSTANDING)));

  assign issue_load = iss_valid && iss_ready && iss_is_load;
  assign dec        = commit && (count != '0);
  assign set_mask   = (issue_load && (iss_rd != 4'd0)) ? (16'd1 << iss_rd) : 16'd0;
  assign clr_mask   = commit ? (16'd1 << commit_rd) : 16'd0;
  assign busy_mask  = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_rd    <= '0;
      skid_data  <= '0;
    end else if (cap_skid) begin
      skid_valid <= 1'b1;
      skid_rd    <= ld_rsp_rd;
      skid_data  <= ld_rsp_data;
    end else if (drain_skid) begin
      skid_valid <= 1'b0;
    end
  end

  // Set is OR'd after the clear so a same-index set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & 16'hFFFE;
      if (issue_load && !dec)      count <= count + CW'(1);
      else if (!issue_load && dec) count <= count - CW'(1);
    end
  end

endmodule
